// File: rtl/mips_fetch_stage.sv
// ---------------------------------------------------------------------------
// mips_fetch_stage
//
// Fetch stage and IF/ID pipeline register of the 5-stage MIPS core.
//
// The stage drives a variable-latency instruction-memory request. It uses
// imem_req / imem_addr, and a request completes in any cycle with
// imem_ready=1. It also absorbs hazard-unit stalls and flushes, and it
// applies branch/jump redirects that decode resolves.
//
// Ports
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   StallF, StallD        hazard unit: hold fetch / hold IF/ID
//   FlushD                hazard unit: load a bubble into IF/ID
//   PCSrcD, PCBranchD     taken branch and its target (from decode)
//   select_jumpD, PCJumpD jump and its target (wins over a branch)
//   imem_req, imem_addr   request and word-aligned address to memory
//   imem_rdata, imem_ready instruction word and completion strobe
//   InstrD, PCPlus4D      IF/ID instruction and PC+4
//   ValidD                IF/ID holds a real instruction
//   PCF                   current fetch PC (trace)
// ---------------------------------------------------------------------------
module mips_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCSrcD,
    input  logic [31:0] PCBranchD,
    input  logic        select_jumpD,
    input  logic [31:0] PCJumpD,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] InstrD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD,
    output logic [31:0] PCF
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      state_q;
    logic        req_q;        // registered request; high exactly in S_REQ
    logic [31:0] pcf_q;        // architectural fetch PC
    logic [31:0] req_addr_q;   // address of the request on the bus
    logic [31:0] instr_q;
    logic [31:0] pcplus4_q;
    logic        valid_q;
    logic        kill_q;       // outstanding request belongs to a squashed path
    logic [31:0] buf_q;        // word parked while fetch/decode are stalled

    logic        accept;
    logic        redirect;
    logic [31:0] target;
    logic [31:0] seq_addr;

    assign accept   = !StallF && !StallD;
    // A stalled decode stage has not really resolved its branch yet.
    assign redirect = (PCSrcD || select_jumpD) && !StallD;
    assign target   = (select_jumpD ? PCJumpD : PCBranchD) & 32'hFFFF_FFFC;
    assign seq_addr = req_addr_q + 32'd4;  // wraps modulo 2^32

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            req_q      <= 1'b0;
            pcf_q      <= RESET_PC;
            req_addr_q <= RESET_PC;
            instr_q    <= NOP_INSTR;
            pcplus4_q  <= 32'h0000_0000;
            valid_q    <= 1'b0;
            kill_q     <= 1'b0;
            buf_q      <= NOP_INSTR;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_q <= S_REQ;
                    req_q   <= 1'b1;
                    if (!StallD) begin
                        instr_q <= NOP_INSTR;
                        valid_q <= 1'b0;
                    end
                end

                S_REQ: begin
                    if (!imem_ready) begin
                        // The bus address must stay put. Remember the new
                        // path in PCF and squash the word when it arrives.
                        if (redirect) begin
                            pcf_q  <= target;
                            kill_q <= 1'b1;
                        end
                        if (!StallD) begin
                            instr_q <= NOP_INSTR;
                            valid_q <= 1'b0;
                        end
                    end else if (kill_q || redirect) begin
                        // The returning word is from the wrong path. Refetch
                        // at once from the pending or current target.
                        req_addr_q <= redirect ? target : pcf_q;
                        pcf_q      <= redirect ? target : pcf_q;
                        kill_q     <= 1'b0;
                        if (!StallD) begin
                            instr_q <= NOP_INSTR;
                            valid_q <= 1'b0;
                        end
                    end else if (accept && !FlushD) begin
                        instr_q    <= imem_rdata;
                        pcplus4_q  <= seq_addr;
                        valid_q    <= 1'b1;
                        pcf_q      <= seq_addr;
                        req_addr_q <= seq_addr;
                    end else if (!StallD && FlushD) begin
                        // Drop the word and ask again for the same address.
                        instr_q <= NOP_INSTR;
                        valid_q <= 1'b0;
                    end else begin
                        // Fetch is stalled. Park the word and drop the
                        // request until the pipeline can take it.
                        buf_q   <= imem_rdata;
                        state_q <= S_HOLD;
                        req_q   <= 1'b0;
                        if (!StallD) begin
                            instr_q <= NOP_INSTR;
                            valid_q <= 1'b0;
                        end
                    end
                end

                S_HOLD: begin
                    if (accept) begin
                        state_q <= S_REQ;
                        req_q   <= 1'b1;
                        if (redirect) begin
                            pcf_q      <= target;
                            req_addr_q <= target;
                            instr_q    <= NOP_INSTR;
                            valid_q    <= 1'b0;
                        end else if (FlushD) begin
                            instr_q <= NOP_INSTR;
                            valid_q <= 1'b0;
                        end else begin
                            instr_q    <= buf_q;
                            pcplus4_q  <= seq_addr;
                            valid_q    <= 1'b1;
                            pcf_q      <= seq_addr;
                            req_addr_q <= seq_addr;
                        end
                    end else if (!StallD) begin
                        // Only fetch is stalled. Decode must not execute the
                        // held instruction a second time.
                        instr_q <= NOP_INSTR;
                        valid_q <= 1'b0;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = req_addr_q;
    assign InstrD    = instr_q;
    assign PCPlus4D  = pcplus4_q;
    assign ValidD    = valid_q;
    assign PCF       = pcf_q;

endmodule

// File: tb/tb_mips_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_mips_fetch_stage
//
// Directed scenarios followed by a randomized phase. The randomized phase is
// checked against an instruction-stream reference model. One instance uses
// RESET_PC=0. A second instance starts at 0xFFFF_FFFC and covers PC
// wrap-around. The memory model has a programmable number of wait states and
// returns an address-derived word.
// ---------------------------------------------------------------------------
module tb_mips_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // main instance
    logic        reset, StallF, StallD, FlushD, PCSrcD, select_jumpD;
    logic [31:0] PCBranchD, PCJumpD;
    logic        imem_req, imem_ready, ValidD;
    logic [31:0] imem_addr, imem_rdata, InstrD, PCPlus4D, PCF;

    // wrap-around instance
    logic        reset_w, StallF_w, StallD_w, FlushD_w, PCSrcD_w, select_jumpD_w;
    logic [31:0] PCBranchD_w, PCJumpD_w;
    logic        imem_req_w, imem_ready_w, ValidD_w;
    logic [31:0] imem_addr_w, imem_rdata_w, InstrD_w, PCPlus4D_w, PCF_w;

    int          checks   = 0;
    int          failures = 0;
    int          wait_n   = 0;

    // memory model state
    int          mem_cnt;
    logic        mem_pend;
    logic [31:0] mem_pend_addr;

    // reference model state for the randomized phase
    logic [31:0] exp_pc, m_instr, m_pc4;
    logic        m_valid;
    int          delivered;
    logic        r_stall, r_br, r_jp, r_fl;
    logic [31:0] r_tb, r_tj, r_tgt;

    mips_fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
        .clk(clk), .reset(reset), .StallF(StallF), .StallD(StallD),
        .FlushD(FlushD), .PCSrcD(PCSrcD), .PCBranchD(PCBranchD),
        .select_jumpD(select_jumpD), .PCJumpD(PCJumpD),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_ready(imem_ready),
        .InstrD(InstrD), .PCPlus4D(PCPlus4D), .ValidD(ValidD), .PCF(PCF)
    );

    mips_fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(NOP)) dut_w (
        .clk(clk), .reset(reset_w), .StallF(StallF_w), .StallD(StallD_w),
        .FlushD(FlushD_w), .PCSrcD(PCSrcD_w), .PCBranchD(PCBranchD_w),
        .select_jumpD(select_jumpD_w), .PCJumpD(PCJumpD_w),
        .imem_req(imem_req_w), .imem_addr(imem_addr_w),
        .imem_rdata(imem_rdata_w), .imem_ready(imem_ready_w),
        .InstrD(InstrD_w), .PCPlus4D(PCPlus4D_w), .ValidD(ValidD_w), .PCF(PCF_w)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[31:16] ^ 16'h1234};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic run_until_addr(input logic [31:0] a, input string tag);
        int n = 0;
        while (!(imem_req === 1'b1 && imem_addr === a) && n < 50) begin
            step();
            n++;
        end
        chk(tag, imem_addr, a);
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] ins,
                            input logic [31:0] pc4, input logic v);
        chk({tag, "_InstrD"}, InstrD, ins);
        chk({tag, "_PCPlus4D"}, PCPlus4D, pc4);
        chk({tag, "_ValidD"}, 32'(ValidD), 32'(v));
    endtask

    // Main memory: wait_n cycles of ready=0, then one ready cycle.
    // It also checks that a pending request is neither moved nor withdrawn.
    initial begin
        mem_cnt = 0; mem_pend = 1'b0; mem_pend_addr = '0;
        imem_ready = 1'b0; imem_rdata = 32'hDEAD_BEEF;
        forever begin
            @(negedge clk);
            if (reset) begin
                mem_cnt = 0; mem_pend = 1'b0;
                imem_ready = 1'b0; imem_rdata = 32'hDEAD_BEEF;
            end else if (imem_req) begin
                if (mem_pend) chk("mem_addr_held", imem_addr, mem_pend_addr);
                if (mem_cnt >= wait_n) begin
                    imem_ready = 1'b1; imem_rdata = mem_word(imem_addr);
                    mem_cnt = 0; mem_pend = 1'b0;
                end else begin
                    imem_ready = 1'b0; imem_rdata = 32'hDEAD_BEEF;
                    mem_cnt++; mem_pend = 1'b1; mem_pend_addr = imem_addr;
                end
            end else begin
                if (mem_pend) chk("mem_req_withdrawn", 32'(imem_req), 32'd1);
                mem_cnt = 0; mem_pend = 1'b0;
                imem_ready = 1'b0; imem_rdata = 32'hDEAD_BEEF;
            end
        end
    end

    // Wrap instance memory: zero wait states.
    initial begin
        imem_ready_w = 1'b0; imem_rdata_w = '0;
        forever begin
            @(negedge clk);
            imem_ready_w = imem_req_w && !reset_w;
            imem_rdata_w = mem_word(imem_addr_w);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
        PCSrcD = 1'b0; select_jumpD = 1'b0; PCBranchD = '0; PCJumpD = '0;
        reset_w = 1'b1; StallF_w = 1'b0; StallD_w = 1'b0; FlushD_w = 1'b0;
        PCSrcD_w = 1'b0; select_jumpD_w = 1'b0; PCBranchD_w = '0; PCJumpD_w = '0;
        wait_n = 0;
        repeat (3) step();

        // reset state
        chk("rst_PCF", PCF, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk_ifid("rst", NOP, 32'h0, 1'b0);
        reset = 1'b0;

        // zero-wait streaming: one instruction per cycle
        step();
        chk("zw_req", 32'(imem_req), 32'd1);
        chk("zw_addr0", imem_addr, 32'h0);
        chk("zw_valid0", 32'(ValidD), 32'd0);
        for (int k = 1; k <= 3; k++) begin
            step();
            chk("zw_addr", imem_addr, 32'(4 * k));
            chk_ifid("zw", mem_word(32'(4 * (k - 1))), 32'(4 * k), 1'b1);
        end

        // 3 wait states at 0x10
        wait_n = 3;
        step();
        chk_ifid("w3_prev", mem_word(32'hC), 32'h10, 1'b1);
        chk("w3_req0", 32'(imem_req), 32'd1);
        chk("w3_addr0", imem_addr, 32'h10);
        for (int i = 1; i <= 3; i++) begin
            step();
            chk("w3_req", 32'(imem_req), 32'd1);
            chk("w3_addr", imem_addr, 32'h10);
            chk("w3_valid", 32'(ValidD), 32'd0);
        end
        wait_n = 0;
        step();
        chk_ifid("w3_done", mem_word(32'h10), 32'h14, 1'b1);
        chk("w3_next", imem_addr, 32'h14);

        // load-use stall as 0x20 completes
        run_until_addr(32'h20, "lu_reach");
        StallF = 1'b1; StallD = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("lu_req_low", 32'(imem_req), 32'd0);
            chk_ifid("lu_hold", mem_word(32'h1C), 32'h20, 1'b1);
        end
        StallF = 1'b0; StallD = 1'b0;
        step();
        chk_ifid("lu_rel", mem_word(32'h20), 32'h24, 1'b1);
        chk("lu_next", imem_addr, 32'h24);
        chk("lu_req", 32'(imem_req), 32'd1);

        // branch during a 2-wait request at 0x40
        run_until_addr(32'h3C, "br_reach");
        wait_n = 2;
        step();
        chk("br_addr40", imem_addr, 32'h40);
        PCSrcD = 1'b1; PCBranchD = 32'h100; FlushD = 1'b1;
        step();
        chk("br_addr_hold", imem_addr, 32'h40);
        chk("br_PCF", PCF, 32'h100);
        chk("br_valid", 32'(ValidD), 32'd0);
        PCSrcD = 1'b0; PCBranchD = '0; FlushD = 1'b0;
        step();
        chk("br_addr_hold2", imem_addr, 32'h40);
        chk("br_valid2", 32'(ValidD), 32'd0);
        wait_n = 0;
        step();
        chk("br_target", imem_addr, 32'h100);
        chk_ifid("br_discard", NOP, 32'h40, 1'b0);
        step();
        chk_ifid("br_first", mem_word(32'h100), 32'h104, 1'b1);

        // jump beats branch; ignored while StallD
        StallF = 1'b1; StallD = 1'b1;
        PCSrcD = 1'b1; PCBranchD = 32'h300; select_jumpD = 1'b1; PCJumpD = 32'h200;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("jp_stall_PCF", PCF, 32'h104);
            chk("jp_stall_req", 32'(imem_req), 32'd0);
            chk_ifid("jp_stall", mem_word(32'h100), 32'h104, 1'b1);
        end
        StallF = 1'b0; StallD = 1'b0;
        step();
        chk("jp_PCF", PCF, 32'h200);
        chk("jp_addr", imem_addr, 32'h200);
        chk("jp_valid", 32'(ValidD), 32'd0);
        PCSrcD = 1'b0; select_jumpD = 1'b0; PCBranchD = '0; PCJumpD = '0;
        step();
        chk_ifid("jp_first", mem_word(32'h200), 32'h204, 1'b1);

        // randomized phase against an instruction-stream model
        exp_pc = 32'h204; m_instr = mem_word(32'h200); m_pc4 = 32'h204;
        m_valid = 1'b1; delivered = 0;
        for (int c = 0; c < 400; c++) begin
            r_stall = ($urandom_range(0, 4) == 0);
            r_br    = ($urandom_range(0, 11) == 0);
            r_jp    = ($urandom_range(0, 15) == 0);
            r_fl    = r_br || r_jp || ($urandom_range(0, 13) == 0);
            r_tb    = $urandom;
            r_tj    = $urandom;
            wait_n  = $urandom_range(0, 3);
            StallF = r_stall; StallD = r_stall; FlushD = r_fl;
            PCSrcD = r_br; select_jumpD = r_jp; PCBranchD = r_tb; PCJumpD = r_tj;
            step();
            if (r_stall) begin
                chk_ifid("rnd_hold", m_instr, m_pc4, m_valid);
            end else if (r_br || r_jp) begin
                chk_ifid("rnd_redir", NOP, m_pc4, 1'b0);
                r_tgt = r_jp ? r_tj : r_tb;
                exp_pc = r_tgt & 32'hFFFF_FFFC;
                m_instr = NOP; m_valid = 1'b0;
            end else if (r_fl) begin
                chk_ifid("rnd_flush", NOP, m_pc4, 1'b0);
                m_instr = NOP; m_valid = 1'b0;
            end else if (ValidD === 1'b1) begin
                chk("rnd_instr", InstrD, mem_word(exp_pc));
                chk("rnd_pc4", PCPlus4D, exp_pc + 32'd4);
                m_instr = mem_word(exp_pc); m_pc4 = exp_pc + 32'd4; m_valid = 1'b1;
                exp_pc = exp_pc + 32'd4;
                delivered++;
            end else begin
                chk_ifid("rnd_bubble", NOP, m_pc4, 1'b0);
                m_instr = NOP; m_valid = 1'b0;
            end
        end
        chk("rnd_progress", 32'(delivered >= 40), 32'd1);

        // asynchronous reset in the middle of a request
        StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
        PCSrcD = 1'b0; select_jumpD = 1'b0; PCBranchD = '0; PCJumpD = '0;
        wait_n = 3;
        step();
        begin
            int n = 0;
            while (imem_req !== 1'b1 && n < 10) begin step(); n++; end
        end
        chk("ar_pre_req", 32'(imem_req), 32'd1);
        reset = 1'b1;
        #1;
        chk("ar_req", 32'(imem_req), 32'd0);
        chk("ar_PCF", PCF, 32'h0);
        chk("ar_addr", imem_addr, 32'h0);
        chk("ar_valid", 32'(ValidD), 32'd0);
        step();
        reset = 1'b0; wait_n = 0;
        step();
        chk("ar_restart", imem_addr, 32'h0);
        chk("ar_restart_req", 32'(imem_req), 32'd1);
        step();
        chk_ifid("ar_first", mem_word(32'h0), 32'h4, 1'b1);

        // PC wrap-around instance
        reset_w = 1'b0;
        step();
        chk("wr_req", 32'(imem_req_w), 32'd1);
        chk("wr_addr0", imem_addr_w, 32'hFFFF_FFFC);
        step();
        chk("wr_addr1", imem_addr_w, 32'h0000_0000);
        chk("wr_instr", InstrD_w, mem_word(32'hFFFF_FFFC));
        chk("wr_pc4", PCPlus4D_w, 32'h0000_0000);
        chk("wr_valid", 32'(ValidD_w), 32'd1);
        reset_w = 1'b1;
        #1;
        chk("wr_ar_req", 32'(imem_req_w), 32'd0);
        chk("wr_ar_PCF", PCF_w, 32'hFFFF_FFFC);
        chk("wr_ar_valid", 32'(ValidD_w), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mips_fetch_stage.md
Name: mips_fetch_stage

Overview:
Fetch stage plus IF/ID pipeline register of the 5-stage MIPS core. It sits directly upstream of the decode stage and hazard unit, and consumes that unit's StallF, StallD and FlushD outputs. It also consumes branch/jump redirects resolved in decode. It drives a variable-latency instruction-memory req/ready handshake and presents InstrD/PCPlus4D/ValidD to decode.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INSTR, 32'h0000_0000, instruction word driven on InstrD for a bubble (sll $0,$0,0).

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
StallF  in  1  hazard unit: hold fetch.
StallD  in  1  hazard unit: hold IF/ID register.
FlushD  in  1  hazard unit: load bubble into IF/ID.
PCSrcD  in  1  taken branch resolved in decode.
PCBranchD  in  32  branch target.
select_jumpD  in  1  jump in decode.
PCJumpD  in  32  jump target.
imem_req  out  1  instruction-memory request.
imem_addr  out  32  request address, word aligned.
imem_rdata  in  32  instruction, valid when imem_ready=1.
imem_ready  in  1  request completes this cycle.
InstrD  out  32  IF/ID instruction.
PCPlus4D  out  32  IF/ID PC+4.
ValidD  out  1  IF/ID holds a real instruction.
PCF  out  32  current fetch PC (debug/trace).

Behaviour:
- One clock, clk. Reset is asynchronous and active-high on reset.
- Reset values: PCF=RESET_PC, req_addr=RESET_PC, InstrD=NOP_INSTR, PCPlus4D=0, ValidD=0, kill_q=0, state=S_IDLE, imem_req=0.
- accept = !StallF && !StallD.
- redirect = (PCSrcD | select_jumpD) && !StallD.
- target = select_jumpD ? PCJumpD : PCBranchD. Jump has priority over branch.
- StallD has priority over FlushD and over redirect. While StallD=1, IF/ID holds all three outputs.
- imem_addr = req_addr. req_addr is stable while imem_req=1 and imem_ready=0. A request is never withdrawn mid-handshake.
- FSM states:
  S_IDLE: imem_req=0; next state S_REQ unconditionally. One cycle after reset deasserts.
  S_REQ: imem_req=1. Branch on imem_ready and conditions, in priority order:
    1. ready=0, redirect: PCF<=target, kill_q<=1, stay S_REQ. IF/ID gets bubble if !StallD.
    2. ready=0, no redirect: stay S_REQ. IF/ID gets bubble (ValidD=0) if !StallD.
    3. ready=1, kill_q|redirect: discard rdata. req_addr<=PCF, or target if redirect this cycle; PCF takes the same value. kill_q<=0; stay S_REQ, which gives a back-to-back request. IF/ID gets bubble if !StallD.
    4. ready=1, accept, !FlushD: InstrD<=rdata, PCPlus4D<=req_addr+4, ValidD<=1, PCF<=req_addr+4, req_addr<=req_addr+4.
    5. ready=1, !StallD, FlushD: discard rdata, bubble into IF/ID; PC does not advance and the same address is refetched.
    6. ready=1, !accept: buf<=rdata; go to S_HOLD.
  S_HOLD: imem_req=0. Stay while !accept. Once accept holds:
    - redirect: discard buf; PCF<=target, req_addr<=target; IF/ID gets bubble; go to S_REQ.
    - FlushD only: discard buf, IF/ID gets bubble, PC unchanged; go to S_REQ.
    - otherwise: InstrD<=buf, PCPlus4D<=req_addr+4, ValidD<=1, PCF/req_addr<=req_addr+4; go to S_REQ.
- Arithmetic: PC+4 is 32-bit and wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000). Target bits [1:0] are forced to 0.
- Latency: with zero-wait memory (ready=1 in the request cycle), one instruction per cycle. InstrD appears the cycle after ready.
- Bubble = InstrD=NOP_INSTR, ValidD=0, PCPlus4D unchanged.
- Reset mid-handshake: state returns to S_IDLE and imem_req drops immediately (asynchronous). The memory model must accept an abandoned request.

Test Plan:
- Reset release, memory with zero wait states returning addr-derived words: imem_addr sequence 0x0,0x4,0x8. InstrD follows one cycle later with PCPlus4D 0x4,0x8,0xC and ValidD=1 each cycle.
- 3-wait-state memory at PC=0x10: imem_req high and imem_addr=0x10 for 4 cycles; ValidD=0 for 3 cycles; then InstrD=mem[0x10], PCPlus4D=0x14.
- Load-use stall: StallF=StallD=1 for 2 cycles when ready arrives for 0x20. IF/ID holds, FSM enters S_HOLD with imem_req=0. After release, InstrD=mem[0x20] and the next request is 0x24.
- Branch during 2-wait request at 0x40, PCSrcD=1, PCBranchD=0x100, FlushD=1: imem_addr stays 0x40 until ready; that word is discarded (ValidD=0); the next request is 0x100; mem[0x100] appears with PCPlus4D=0x104.
- select_jumpD=1 (PCJumpD=0x200) and PCSrcD=1 (PCBranchD=0x300) in the same cycle -> next fetch is 0x200. The same redirect with StallD=1 is ignored until StallD=0.
- PC wrap: RESET_PC=0xFFFFFFFC -> requests 0xFFFFFFFC then 0x00000000. Async reset asserted mid-request -> imem_req=0 and PCF=RESET_PC in the same cycle.
